// File: rtl/stream_pattern_tx.sv
// Valid/ready stream source: emits an incrementing data pattern with a
// programmable beat count and idle gap, and honours sink backpressure.
`timescale 1ns/1ps
module stream_pattern_tx #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned STEP   = 1,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned GAP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [LEN_W-1:0]  len,
    input  logic [GAP_W-1:0]  gap,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  beat_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        r_state;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_dout;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic [LEN_W-1:0]  r_len;
    logic [GAP_W-1:0]  r_gap;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_stop_pend;

    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] w_dout_nxt;
    logic [LEN_W-1:0]  w_beat_cnt_nxt;
    logic [LEN_W-1:0]  w_len_nxt;
    logic [GAP_W-1:0]  w_gap_nxt;
    logic [GAP_W-1:0]  w_gap_cnt_nxt;
    logic              w_stop_pend_nxt;
    logic              w_xfer;
    logic              w_last;
    logic [LEN_W-1:0]  w_cnt_inc;
    logic [DATA_W-1:0] w_dout_inc;

    assign w_xfer     = r_valid & ready;
    assign w_cnt_inc  = r_beat_cnt + LEN_W'(1);
    assign w_dout_inc = r_dout + DATA_W'(STEP);
    // len of zero means continuous: the count wraps and never ends the run
    assign w_last     = (r_len != '0) && (w_cnt_inc == r_len);

    // Next-state and datapath update
    always_comb begin
        w_state_nxt     = r_state;
        w_dout_nxt      = r_dout;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_len_nxt       = r_len;
        w_gap_nxt       = r_gap;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_stop_pend_nxt = r_stop_pend;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_len_nxt       = len;
                    w_gap_nxt       = gap;
                    w_dout_nxt      = seed;
                    w_beat_cnt_nxt  = '0;
                    w_stop_pend_nxt = 1'b0;
                    w_state_nxt     = S_SEND;
                end
            end
            S_SEND: begin
                if (w_xfer) begin
                    w_beat_cnt_nxt = w_cnt_inc;
                    w_dout_nxt     = w_dout_inc;
                    if (w_last || stop || r_stop_pend) begin
                        w_state_nxt = S_DONE;
                    end else if (r_gap == '0) begin
                        w_state_nxt = S_SEND;
                    end else begin
                        w_gap_cnt_nxt = r_gap;
                        w_state_nxt   = S_GAP;
                    end
                end else if (stop) begin
                    // a stop seen while a beat is pending ends the run after it transfers
                    w_stop_pend_nxt = 1'b1;
                end
            end
            S_GAP: begin
                if (stop) begin
                    w_state_nxt = S_DONE;
                end else if (r_gap_cnt == GAP_W'(1)) begin
                    w_state_nxt = S_SEND;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; status flags follow the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dout      <= '0;
            r_beat_cnt  <= '0;
            r_len       <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_stop_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_valid     <= (w_state_nxt == S_SEND);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
            r_dout      <= w_dout_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_len       <= w_len_nxt;
            r_gap       <= w_gap_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_stop_pend <= w_stop_pend_nxt;
        end
    end

    assign dout     = r_dout;
    assign valid    = r_valid;
    assign busy     = r_busy;
    assign done     = r_done;
    assign beat_cnt = r_beat_cnt;

endmodule

// File: doc/stream_pattern_tx.md
Name: stream_pattern_tx

Overview:
Synthesizable valid/ready stream transmitter that drives one input channel of the two-operand stream adder. It replaces the bench-only incrementing drivers on dinp_a/dinp_b with a programmable source. It emits an incrementing data pattern with a programmable beat count and inter-beat idle gap, and it honours downstream backpressure. Two instances, one per channel, sit in front of the adder in hardware self-test builds.

Parameters:
DATA_W, 16, data width; matches the adder operand width (DATA_WIDTH).
STEP, 1, increment added to the data word after each accepted beat.
LEN_W, 16, width of the beat-count input.
GAP_W, 8, width of the idle-gap input.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  one-cycle request to begin a run; sampled only in IDLE.
stop  input  1  level request to end a run early.
len  input  LEN_W  number of beats in the run; 0 = continuous until stop.
gap  input  GAP_W  idle cycles inserted after each accepted beat.
seed  input  DATA_W  first data word of the run.
dout  output  DATA_W  stream data.
valid  output  1  stream valid.
ready  input  1  stream ready from the sink.
busy  output  1  high from the cycle after start is accepted until DONE.
done  output  1  one-cycle pulse when a run ends.
beat_cnt  output  LEN_W  number of beats accepted in the current or last run.

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-low on rst_n. While rst_n=0 at a clk edge, the block is forced to: state=IDLE, valid=0, dout=0, busy=0, done=0, beat_cnt=0.
- A reset mid-run takes effect at the next clk edge regardless of handshake state. An in-flight beat is abandoned.
- Handshake: a beat transfers on any cycle with valid=1 and ready=1.
  - Once valid rises, valid and dout stay stable until the transfer.
  - valid never depends combinationally on ready; dout and valid are registered.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - valid=0, busy=0.
  - On start=1: latch len, gap and seed; set dout=seed and beat_cnt=0; go to SEND.
  - valid=1 appears in the next cycle, so latency from start to first valid is 1 cycle.
- SEND: valid=1. On transfer:
  - beat_cnt increments; dout advances to dout+STEP, modulo 2^DATA_W (wraps silently).
  - If len!=0 and the new beat_cnt equals len, or stop=1 in the transfer cycle: go to DONE, valid=0.
  - Else, if gap=0: stay in SEND with valid=1. Back-to-back beats at 1 beat/cycle are possible under ready=1.
  - Else: go to GAP with valid=0 and load the gap counter with gap.
- SEND without transfer:
  - Hold everything.
  - A stop asserted while the beat is pending does not drop valid. The pending beat must complete, after which the block goes to DONE.
- GAP:
  - valid=0; the counter decrements each cycle.
  - When the counter reaches 1, go to SEND, so exactly gap idle cycles occur.
  - stop=1 in GAP goes to DONE on the next edge without emitting another beat.
- DONE: done=1 for exactly one cycle; busy falls with done. Next state is IDLE.
- start outside IDLE is ignored. start asserted in the DONE cycle is ignored.
- The len, gap and seed inputs may change freely while busy; only the values latched at start are used.
- beat_cnt holds its final value in IDLE until the next start clears it.
- Continuous mode (len=0): beat_cnt wraps modulo 2^LEN_W and does not terminate the run.

Test Plan:
1. Reset, then start with seed=1, len=4, gap=0, ready=1 constant -> valid high for 4 consecutive cycles with dout=1,2,3,4; done pulses one cycle after the last beat; beat_cnt=4.
2. seed=5, len=3, gap=2, ready=1 -> beats 5, 6, 7, each followed by exactly 2 valid=0 cycles (no gap after the final beat); done pulses; beat_cnt=3.
3. Backpressure: seed=0, len=3, gap=0, ready toggling 1,0,0,1,0,1 -> dout holds while ready=0 and never changes without a transfer; the sink receives 0, 1, 2.
4. Wrap: DATA_W=16, seed=16'hFFFE, len=3 -> dout=FFFE, FFFF, 0000.
5. Early stop: len=0, gap=0, ready=0 at the third beat while stop=1 -> valid is held until ready=1, then that beat transfers, done pulses, beat_cnt=3. A second run with stop=1 in GAP -> no further beat, done on the next cycle.
6. Reset mid-run: rst_n=0 during SEND with valid=1, ready=0 -> the next cycle shows valid=0, busy=0, beat_cnt=0, state IDLE. A start in the same run while busy -> no effect on dout or the counters.
